mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles waiting for dm_ack per request (legal 1..255).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rsta  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  MEM-stage op valid, from EX/MEM register.
REQ-005 in_allow  out  1  block accepts a new op; drives EX/MEM allow_in.
REQ-006 addr  in  32  byte address (ALU result).
REQ-007 wdat  in  32  store data.
REQ-008 mem_en  in  1  op accesses data memory.
REQ-009 mem_wen  in  1  store when 1, load when 0.
REQ-010 byte_en  in  1  byte-sized access when 1, word when 0.
REQ-011 dm_req  out  1  memory request, held until dm_ack.
REQ-012 dm_we  out  1  request is a write.
REQ-013 dm_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-014 dm_wdata  out  32  write word.
REQ-015 dm_rdata  in  32  read word, valid in the dm_ack cycle.
REQ-016 dm_ack  in  1  request completes this cycle.
REQ-017 out_valid  out  1  result available to MEM/WB.
REQ-018 out_allow  in  1  MEM/WB consumes the result this cycle.
REQ-019 out_rdata  out  32  load result; 0 for non-loads.
REQ-020 err  out  1  sticky timeout flag.

Function
REQ-021 The FSM SHALL have states IDLE, RD, RMW_RD, WR.
REQ-022 in_allow SHALL equal (state==IDLE) && (!out_valid || out_allow); an op is accepted when in_valid && in_allow, latching addr, wdat, mem_wen, byte_en.
REQ-023 Accepted op with mem_en=0 SHALL stay in IDLE and assert out_valid next cycle, out_rdata=0.
REQ-024 Accepted load SHALL go IDLE->RD; byte store SHALL go IDLE->RMW_RD; word store SHALL go IDLE->WR.
REQ-025 dm_req SHALL be 1 exactly in RD, RMW_RD, WR; dm_we=1 only in WR; dm_addr/dm_wdata SHALL stay stable while dm_req=1 and dm_ack=0.
REQ-026 RD + dm_ack: word load -> out_rdata=dm_rdata; byte load -> out_rdata = zero-extended byte at lane addr[1:0] (little-endian, lane0=bits 7:0); out_valid=1 next cycle; state->IDLE.
REQ-027 RMW_RD + dm_ack: capture dm_rdata, replace lane addr[1:0] with wdat[7:0], go to WR with the merged word as dm_wdata.
REQ-028 WR + dm_ack: out_valid=1 next cycle, out_rdata=0, state->IDLE.
REQ-029 Minimum latency from accept cycle N: non-mem out_valid at N+1; load/word store with immediate ack at N+2; byte store at N+3.
REQ-030 out_valid SHALL clear on out_valid && out_allow unless a new completion occurs in the same cycle, in which case it stays 1 with new out_rdata.
REQ-031 An 8-bit wait counter SHALL clear on entering RD/RMW_RD/WR and increment each cycle without dm_ack; reaching TIMEOUT SHALL set err, drop dm_req, complete the op with out_rdata=0, state->IDLE.
REQ-032 err SHALL remain 1 until reset; subsequent ops proceed normally.
REQ-033 dm_ack outside RD/RMW_RD/WR SHALL be ignored.

Reset
REQ-034 rsta SHALL immediately force state=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, out_valid=0, out_rdata=0, err=0, counter=0; an in-flight op is discarded.

Structure
REQ-035 State encoding and TIMEOUT default SHALL reside in the shared package mem_pkg.
REQ-036 Byte-lane extract/merge SHALL be a combinational sub-module byte_lane_unit (inputs word, lane, byte; outputs extracted byte, merged word).

Verification
REQ-037 Non-mem op accepted cycle N, out_allow=1 -> out_valid=1 at N+1, out_rdata=0, dm_req never asserted.
REQ-038 Byte load addr=0x13, dm_rdata=0xAABBCCDD, ack after 3 wait cycles -> out_rdata=0x000000AA, dm_addr=0x10 held stable throughout.
REQ-039 Byte store addr=0x21, wdat=0x55, read returns 0x11223344 -> WR with dm_wdata=0x11225544, dm_we=1.
REQ-040 out_allow=0 with out_valid=1 -> in_allow=0; a second op is accepted only in the cycle out_allow rises.
REQ-041 TIMEOUT=4, no dm_ack -> dm_req drops after 4 cycles, err=1, out_valid=1 with out_rdata=0; next word load completes normally.
REQ-042 rsta pulse while in RMW_RD -> dm_req=0 immediately, out_valid=0, state IDLE, no write issued.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// FSM state encoding, default timeout and wait-counter width.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD     = 2'd1,
    RMW_RD = 2'd2,
    WR     = 2'd3
  } state_e;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int WAIT_CNT_W      = 8;

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian byte-lane helper: pulls one byte out of a word and builds
// the word with that same lane overwritten (lane 0 = bits 7:0).
module byte_lane_unit (
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
  output logic [7:0]  byte_o,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = word_i;
    byte_o   = word_i[{lane_i, 3'b000} +: 8];
    merged_o[{lane_i, 3'b000} +: 8] = byte_i;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns pipeline ops into single-word memory requests,
// does read-modify-write for byte stores and flags requests that never get acked.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rsta,
  input  logic        in_valid,
  output logic        in_allow,
  input  logic [31:0] addr,
  input  logic [31:0] wdat,
  input  logic        mem_en,
  input  logic        mem_wen,
  input  logic        byte_en,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        out_valid,
  input  logic        out_allow,
  output logic [31:0] out_rdata,
  output logic        err
);

  localparam logic [WAIT_CNT_W-1:0] WaitLast = WAIT_CNT_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           dm_addr_q, dm_addr_d;
  logic [31:0]           dm_wdata_q, dm_wdata_d;
  logic [1:0]            lane_q, lane_d;
  logic                  byte_q, byte_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_rdata_q, out_rdata_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  done;
  logic [31:0]           done_rdata;
  logic [7:0]            lane_byte;
  logic [31:0]           merged_word;

  // During RMW_RD dm_wdata_q still holds the store data, so its low byte is the byte to merge.
  byte_lane_unit u_lane (
    .word_i   (dm_rdata),
    .lane_i   (lane_q),
    .byte_i   (dm_wdata_q[7:0]),
    .byte_o   (lane_byte),
    .merged_o (merged_word)
  );

  assign in_allow  = (state_q == IDLE) && (!out_valid_q || out_allow);
  assign accept    = in_valid && in_allow;
  assign dm_req    = (state_q != IDLE);
  assign dm_we     = (state_q == WR);
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  assign out_valid = out_valid_q;
  assign out_rdata = out_rdata_q;
  assign err       = err_q;

  always_ff @(posedge clk or posedge rsta) begin
    if (rsta) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      lane_q      <= '0;
      byte_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      lane_q      <= lane_d;
      byte_q      <= byte_d;
      out_valid_q <= out_valid_d;
      out_rdata_q <= out_rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    lane_d      = lane_q;
    byte_d      = byte_q;
    out_valid_d = out_valid_q;
    out_rdata_d = out_rdata_q;
    err_d       = err_q;
    done        = 1'b0;
    done_rdata  = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          dm_addr_d  = {addr[31:2], 2'b00};
          dm_wdata_d = wdat;
          lane_d     = addr[1:0];
          byte_d     = byte_en;
          cnt_d      = '0;
          if (!mem_en) begin
            done = 1'b1;
          end else if (!mem_wen) begin
            state_d = RD;
          end else if (byte_en) begin
            state_d = RMW_RD;
          end else begin
            state_d = WR;
          end
        end
      end
      RD: begin
        if (dm_ack) begin
          done       = 1'b1;
          done_rdata = byte_q ? {24'h000000, lane_byte} : dm_rdata;
          state_d    = IDLE;
        end
      end
      RMW_RD: begin
        if (dm_ack) begin
          dm_wdata_d = merged_word;
          cnt_d      = '0;
          state_d    = WR;
        end
      end
      WR: begin
        if (dm_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A request phase that runs out of wait cycles completes the op with a zero result.
    if ((state_q != IDLE) && !dm_ack) begin
      if (cnt_q == WaitLast) begin
        err_d      = 1'b1;
        done       = 1'b1;
        done_rdata = '0;
        state_d    = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (out_valid_q && out_allow) begin
      out_valid_d = 1'b0;
    end
    if (done) begin
      out_valid_d = 1'b1;
      out_rdata_d = done_rdata;
    end
  end

endmodule
